// File: rtl/counter_days_if.sv
// Calendar-chain bundle between the day counter and its neighbours:
// tick/adjust controls, month/year BCD digits in, day BCD digits and tick_month out.
interface counter_days_if;
  logic       mode_day;
  logic       up;
  logic       down;
  logic       tick_day;
  logic [3:0] month_unit;
  logic [3:0] month_ten;
  logic [3:0] year_unit;
  logic [3:0] year_ten;
  logic [3:0] year_hundred;
  logic [3:0] year_thousand;
  logic [3:0] day_unit;
  logic [3:0] day_ten;
  logic       tick_month;

  modport master (
    output mode_day, up, down, tick_day,
    output month_unit, month_ten,
    output year_unit, year_ten, year_hundred, year_thousand,
    input  day_unit, day_ten, tick_month
  );

  modport slave (
    input  mode_day, up, down, tick_day,
    input  month_unit, month_ten,
    input  year_unit, year_ten, year_hundred, year_thousand,
    output day_unit, day_ten, tick_month
  );
endinterface

// File: rtl/counter_days.sv
// BCD day-of-month counter with run/adjust modes and month-length clamping.
// Define COUNTER_DAYS_LEAP_EN to enable the Gregorian leap rule; otherwise February has 28 days.
module counter_days (
  input  logic          clk,
  input  logic          rst_n,
  counter_days_if.slave cal
);

  logic [7:0] monthCode;
  logic [7:0] maxDay;
  logic       isLeap;
  logic [7:0] dayBcd_q, dayBcd_d;
  logic       tickMonth_q, tickMonth_d;
  logic [7:0] dayInc;
  logic [7:0] dayDec;
  logic       doInc;
  logic       doDec;

  assign monthCode = {cal.month_ten, cal.month_unit};

`ifdef COUNTER_DAYS_LEAP_EN
  // Divisibility by 4 of a two-digit BCD number, decided from the digit pattern alone.
  function automatic logic bcdDiv4(input logic [3:0] tens, input logic [3:0] units);
    if (!tens[0])
      return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
    else
      return (units == 4'd2) || (units == 4'd6);
  endfunction

  always_comb begin
    if ({cal.year_ten, cal.year_unit} != 8'h00)
      isLeap = bcdDiv4(cal.year_ten, cal.year_unit);
    else
      isLeap = bcdDiv4(cal.year_thousand, cal.year_hundred);
  end
`else
  logic unusedYear;
  assign unusedYear = ^{cal.year_thousand, cal.year_hundred, cal.year_ten, cal.year_unit};
  assign isLeap     = 1'b0;
`endif

  always_comb begin
    case (monthCode)
      8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: maxDay = 8'h31;
      8'h04, 8'h06, 8'h09, 8'h11:                      maxDay = 8'h30;
      8'h02:                                           maxDay = isLeap ? 8'h29 : 8'h28;
      default:                                         maxDay = 8'h31;
    endcase
  end

  // BCD neighbours of the current day; comparisons on the packed BCD byte order correctly.
  always_comb begin
    if (dayBcd_q[3:0] == 4'd9)
      dayInc = {dayBcd_q[7:4] + 4'd1, 4'd0};
    else
      dayInc = {dayBcd_q[7:4], dayBcd_q[3:0] + 4'd1};

    if (dayBcd_q == 8'h01)
      dayDec = maxDay;
    else if (dayBcd_q[3:0] == 4'd0)
      dayDec = {dayBcd_q[7:4] - 4'd1, 4'd9};
    else
      dayDec = {dayBcd_q[7:4], dayBcd_q[3:0] - 4'd1};
  end

  assign doInc = cal.mode_day ? cal.tick_day : (cal.up & ~cal.down);
  assign doDec = ~cal.mode_day & cal.down & ~cal.up;

  always_comb begin
    dayBcd_d    = dayBcd_q;
    tickMonth_d = 1'b0;
    if (doInc) begin
      if (dayBcd_q >= maxDay) begin
        dayBcd_d    = 8'h01;
        tickMonth_d = cal.mode_day;
      end else begin
        dayBcd_d = dayInc;
      end
    end else if (doDec) begin
      dayBcd_d = dayDec;
    end else if (dayBcd_q > maxDay) begin
      dayBcd_d = maxDay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dayBcd_q    <= 8'h01;
      tickMonth_q <= 1'b0;
    end else begin
      dayBcd_q    <= dayBcd_d;
      tickMonth_q <= tickMonth_d;
    end
  end

  assign cal.day_ten    = dayBcd_q[7:4];
  assign cal.day_unit   = dayBcd_q[3:0];
  assign cal.tick_month = tickMonth_q;

endmodule

// File: tb/tb_counter_days.sv
// Bench for counter_days: directed vector table, hand-written corner sequences,
// and a randomized run against an integer calendar model.
module tb_counter_days;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  counter_days_if cal();

  counter_days dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cal   (cal)
  );

  typedef struct {
    bit         mode;
    bit         up;
    bit         down;
    bit         tick;
    logic [7:0] month;
    logic [15:0] year;
    int         preset;
    int         expDay;
    bit         expTm;
  } vec_t;

  vec_t vecs[$];

  // Calendar reference: plain integers and the textbook Gregorian rule.
  function automatic int refMaxDay(input logic [7:0] m, input logic [15:0] y);
    int  mt, mu, mon, yr;
    bit  leap;
    mt = int'(m[7:4]);
    mu = int'(m[3:0]);
    if (mt > 9 || mu > 9) return 31;
    mon = mt * 10 + mu;
    yr  = int'(y[15:12]) * 1000 + int'(y[11:8]) * 100 + int'(y[7:4]) * 10 + int'(y[3:0]);
`ifdef COUNTER_DAYS_LEAP_EN
    leap = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
`else
    leap = (yr < 0);
`endif
    case (mon)
      1, 3, 5, 7, 8, 10, 12: return 31;
      4, 6, 9, 11:           return 30;
      2:                     return leap ? 29 : 28;
      default:               return 31;
    endcase
  endfunction

  function automatic bit leapEnabled();
`ifdef COUNTER_DAYS_LEAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic driveInputs(input bit mode, input bit up, input bit down, input bit tick,
                             input logic [7:0] month, input logic [15:0] year);
    cal.mode_day      = mode;
    cal.up            = up;
    cal.down          = down;
    cal.tick_day      = tick;
    cal.month_ten     = month[7:4];
    cal.month_unit    = month[3:0];
    cal.year_thousand = year[15:12];
    cal.year_hundred  = year[11:8];
    cal.year_ten      = year[7:4];
    cal.year_unit     = year[3:0];
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int expDay, input bit expTm);
    logic [7:0] want;
    logic [7:0] got;
    want = {4'(expDay / 10), 4'(expDay % 10)};
    got  = {cal.day_ten, cal.day_unit};
    total++;
    if (got !== want || cal.tick_month !== expTm) begin
      bad++;
      $display("[TB] FAIL %s: day=%h tick_month=%b, want day=%h tick_month=%b",
               name, got, cal.tick_month, want, expTm);
    end
  endtask

  // Reset, then walk up to the requested day in adjust mode with a 31-day month.
  task automatic setDay(input int d);
    driveInputs(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'h2023);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    cal.up = 1'b1;
    repeat (d - 1) applyStimulus();
    cal.up = 1'b0;
  endtask

  task automatic addVec(input bit mode, input bit up, input bit down, input bit tick,
                        input logic [7:0] month, input logic [15:0] year,
                        input int preset, input int expDay, input bit expTm);
    vec_t v;
    v.mode = mode; v.up = up; v.down = down; v.tick = tick;
    v.month = month; v.year = year; v.preset = preset;
    v.expDay = expDay; v.expTm = expTm;
    vecs.push_back(v);
  endtask

  initial begin
    int  modelDay;
    bit  modelTm;
    bit  m, u, dn, t;
    logic [7:0]  mon;
    logic [15:0] yr;
    int  mx;
    bit  inc, dec;
    logic [15:0] years[4] = '{16'h2024, 16'h2023, 16'h1900, 16'h2000};

    // mode up down tick month year preset -> day tick_month
    addVec(1, 0, 0, 1, 8'h01, 16'h2023, 31, 1, 1);
    addVec(1, 0, 0, 1, 8'h01, 16'h2023, 15, 16, 0);
    addVec(1, 0, 0, 1, 8'h01, 16'h2023, 19, 20, 0);
    addVec(1, 0, 0, 1, 8'h04, 16'h2023, 30, 1, 1);
    addVec(1, 0, 0, 1, 8'h02, 16'h2024, 28, leapEnabled() ? 29 : 1, !leapEnabled());
    addVec(1, 0, 0, 1, 8'h02, 16'h2024, 29, 1, 1);
    addVec(1, 0, 0, 1, 8'h02, 16'h2023, 28, 1, 1);
    addVec(1, 0, 0, 1, 8'h02, 16'h1900, 28, 1, 1);
    addVec(1, 0, 0, 1, 8'h02, 16'h2000, 28, leapEnabled() ? 29 : 1, !leapEnabled());
    addVec(0, 0, 1, 0, 8'h04, 16'h2023, 1, 30, 0);
    addVec(0, 1, 0, 0, 8'h04, 16'h2023, 30, 1, 0);
    addVec(0, 0, 1, 0, 8'h04, 16'h2023, 10, 9, 0);
    addVec(0, 1, 1, 0, 8'h04, 16'h2023, 17, 17, 0);
    addVec(0, 0, 1, 0, 8'h02, 16'h2024, 1, leapEnabled() ? 29 : 28, 0);
    addVec(1, 0, 0, 0, 8'h06, 16'h2023, 20, 20, 0);
    addVec(1, 0, 0, 1, 8'h13, 16'h2023, 31, 1, 1);
    addVec(1, 0, 0, 1, 8'h00, 16'h2023, 30, 31, 0);
    addVec(1, 0, 0, 1, 8'h1A, 16'h2023, 30, 31, 0);
    addVec(0, 0, 0, 0, 8'h06, 16'h2023, 31, 30, 0);
    addVec(1, 0, 0, 0, 8'h02, 16'h2023, 31, 28, 0);
    addVec(0, 1, 0, 1, 8'h09, 16'h2023, 29, 30, 0);
    addVec(1, 1, 0, 0, 8'h11, 16'h2023, 30, 30, 0);

    driveInputs(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'h2023);
    rst_n = 1'b0;
    applyStimulus();
    checkOutput("reset_state", 1, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      setDay(vecs[i].preset);
      driveInputs(vecs[i].mode, vecs[i].up, vecs[i].down, vecs[i].tick, vecs[i].month, vecs[i].year);
      applyStimulus();
      checkOutput($sformatf("vec%0d", i), vecs[i].expDay, vecs[i].expTm);
    end

    // Asynchronous reset mid-count, then idle hold.
    setDay(17);
    checkOutput("preset17", 17, 0);
    driveInputs(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 16'h2023);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput($sformatf("reset_hold%0d", i), 1, 0);
    end

    // Reset clears a pending tick_month.
    setDay(31);
    driveInputs(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 16'h2023);
    applyStimulus();
    checkOutput("rollover_pre_reset", 1, 1);
    cal.tick_day = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_clears_tick", 1, 0);
    rst_n = 1'b1;

    // Thirty back-to-back ticks through January, then the rollover pulse.
    setDay(1);
    driveInputs(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 16'h2023);
    for (int i = 2; i <= 31; i++) begin
      applyStimulus();
      checkOutput($sformatf("jan_day%0d", i), i, 0);
    end
    applyStimulus();
    checkOutput("jan_rollover", 1, 1);
    cal.tick_day = 1'b0;
    applyStimulus();
    checkOutput("jan_pulse_single", 1, 0);

    // Month shrinks under the day.
    setDay(31);
    driveInputs(1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 16'h2023);
    applyStimulus();
    checkOutput("clamp_jun", 30, 0);
    driveInputs(1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 16'h2023);
    applyStimulus();
    checkOutput("clamp_feb", 28, 0);
    applyStimulus();
    checkOutput("clamp_feb_hold", 28, 0);

    // Holds: up=down=1 in adjust, toggling up while running without ticks.
    setDay(17);
    driveInputs(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 16'h2023);
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput($sformatf("hold_updown%0d", i), 17, 0);
    end
    cal.mode_day = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cal.up   = i[0];
      cal.down = 1'b0;
      applyStimulus();
      checkOutput($sformatf("hold_run%0d", i), 17, 0);
    end

    // Randomized run against the integer model.
    mon = 8'h01;
    yr  = 16'h2024;
    driveInputs(1'b1, 1'b0, 1'b0, 1'b0, mon, yr);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    modelDay = 1;
    modelTm  = 1'b0;
    for (int i = 0; i < 800; i++) begin
      m  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1);
      dn = $urandom_range(0, 1);
      t  = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 9) < 8) begin
          int k;
          k   = $urandom_range(1, 12);
          mon = {4'(k / 10), 4'(k % 10)};
        end else begin
          mon = 8'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 1) == 0)
          yr = years[$urandom_range(0, 3)];
        else
          yr = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      driveInputs(m, u, dn, t, mon, yr);
      mx  = refMaxDay(mon, yr);
      inc = m ? t : (u && !dn);
      dec = !m && dn && !u;
      modelTm = 1'b0;
      if (inc) begin
        if (modelDay >= mx) begin
          modelDay = 1;
          modelTm  = m;
        end else begin
          modelDay = modelDay + 1;
        end
      end else if (dec) begin
        modelDay = (modelDay == 1) ? mx : modelDay - 1;
      end else if (modelDay > mx) begin
        modelDay = mx;
      end
      applyStimulus();
      checkOutput($sformatf("rand%0d", i), modelDay, modelTm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_days.md
# counter_days

Day-of-month counter for the clock's calendar chain. It consumes `tick_day` from the hours stage and produces the `tick_month` pulse that drives the month counter. It reads the month counter's BCD outputs and the year digits to determine month length: 28/29/30/31, with the Gregorian leap rule. It supports the same run/adjust split as the other calendar counters.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode_day` in 1: 1 = run (count `tick_day`); 0 = manual adjust via `up`/`down`.
- `up` in 1: adjust increment, level-sampled each cycle.
- `down` in 1: adjust decrement, level-sampled each cycle.
- `tick_day` in 1: one-cycle pulse, advance one day.
- `month_unit` in 4: month BCD units, from the month counter.
- `month_ten` in 4: month BCD tens, from the month counter.
- `year_unit` in 4: year BCD digit 0.
- `year_ten` in 4: year BCD digit 1.
- `year_hundred` in 4: year BCD digit 2.
- `year_thousand` in 4: year BCD digit 3.
- `day_unit` out 4: day BCD units.
- `day_ten` out 4: day BCD tens.
- `tick_month` out 1: registered one-cycle pulse on month rollover.

## Operation
- **Month length (combinational `max_day`):**
  - Months 01, 03, 05, 07, 08, 10, 12 → 31.
  - Months 04, 06, 09, 11 → 30.
  - Month 02 → 29 if leap, else 28.
  - Any invalid month code (00, 13–99, non-BCD) → 31.
- **Leap rule:**
  - Let YY = `year_ten`:`year_unit` and HH = `year_thousand`:`year_hundred`.
  - A 2-digit BCD value is divisible by 4 iff (tens even and units ∈ {0,4,8}) or (tens odd and units ∈ {2,6}).
  - The year is leap iff (YY ≠ 00 and YY div-by-4) or (YY = 00 and HH div-by-4).
  - Examples: 2024 leap; 2023 not; 1900 not; 2000 leap.
- **Run mode (`mode_day` = 1):**
  - `tick_day` = 0: hold the day; `tick_month` ← 0.
  - `tick_day` = 1 and day ≥ `max_day`: day ← 01, `tick_month` ← 1.
  - `tick_day` = 1 otherwise: BCD increment (x9 → (x+1)0); `tick_month` ← 0.
- **Adjust mode (`mode_day` = 0); `tick_month` is always 0:**
  - {up,down} = 10: increment; day ≥ `max_day` wraps to 01.
  - {up,down} = 01: decrement; 01 wraps to `max_day`; x0 → (x−1)9.
  - {up,down} = 00 or 11: hold.
- **Clamp:** in any cycle with no increment/decrement action and day > `max_day` (the month or year changed underneath), day ← `max_day`. This applies in both modes and never generates `tick_month`.
- Day value is always BCD in 01..31 after reset; 00 is never produced.
- `max_day` is evaluated from the inputs present at the same edge; no input registering.

## Timing
- Reset (async assert, sync-to-clk deassert by the system): `day_ten`/`day_unit` = 0/1, `tick_month` = 0.
- Reset mid-count or mid-adjust returns immediately to 01; any pending `tick_month` is cleared.
- Latency: the day updates on the edge sampling `tick_day`/`up`/`down`.
- `tick_month` is high for exactly the cycle following the rollover edge; the day already reads 01 in that cycle.
- The month counter advances one cycle after the day rollover. Until then `max_day` still reflects the old month; this is harmless because the day is 01.
- Back-to-back `tick_day` pulses on consecutive cycles are each counted.
- `tick_month` never asserts two cycles in a row unless the month length is 1, which cannot occur.
- A switch of `mode_day` takes effect at the next edge; no state is lost.

## Configuration
- `COUNTER_DAYS_LEAP_EN` defined: full Gregorian leap rule as above.
- Undefined: February is always 28 days. The year inputs remain as ports but are ignored, and the leap logic is not synthesized.

## Test plan
- Reset with day forced mid-count (e.g. 17) → day 01, `tick_month` 0 immediately; holds 01 through 5 idle cycles.
- Run mode, month 01, count 30 `tick_day` pulses from 01 → day 31, `tick_month` 0. Next pulse → day 01 and a single-cycle `tick_month`.
- Run mode, month 02, LEAP_EN defined:
  - Year 2024, day 28: tick → 29; tick → 01 + `tick_month`.
  - Year 2023 and year 1900, day 28: tick → 01 + `tick_month`.
  - Year 2000, day 28: tick → 29.
  - With the macro undefined, year 2024, day 28: tick → 01.
- Adjust mode, month 04:
  - day 01 with down → 30.
  - day 30 with up → 01.
  - day 10 with down → 09.
  - `tick_month` stays 0 throughout.
- Clamp: day 31 with month 01, switch month inputs to 06 with no tick → day 30 next cycle. Switch to 02 with year 2023 → 28; `tick_month` stays 0.
- Adjust with up = down = 1, and run mode with `tick_day` = 0 under toggling `up` → day unchanged for 10 cycles.
